rx_word_assembler: RTL

//  Downstream stage of the CDC link, in the RXClk domain. Collects the
//  LSB-first serial bit stream (RXData qualified by RXReady) into a

---
 rtl/rx_word_assembler.sv | 122 ++++++++++++
 1 files changed

// File: rtl/rx_word_assembler.sv
// Receive-domain word assembler: gathers an LSB-first serial stream into a
// programmable-length parallel word and hands it off on a valid/accept handshake.
module rx_word_assembler #(
    parameter int unsigned MAXW = 300,
    parameter int unsigned LENW = 9
) (
    input  logic            RXClk,
    input  logic            resetN,
    input  logic            start,
    input  logic [LENW-1:0] wordLen,
    input  logic            RXData,
    input  logic            RXReady,
    output logic            RXAccept,
    output logic [MAXW-1:0] outWord,
    output logic [LENW-1:0] outLen,
    output logic            outValid,
    input  logic            outAccept,
    output logic            busy,
    output logic            dropped,
    output logic            lenErr
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } asmState_t;

    asmState_t       state;
    asmState_t       stateNext;
    logic [LENW-1:0] count;
    logic [LENW-1:0] countNext;
    logic [MAXW-1:0] wordNext;
    logic [LENW-1:0] lenNext;
    logic            droppedNext;
    logic            lenErrNext;
    logic            restart;
    logic            lenOk;

    assign lenOk = (wordLen != '0) && (wordLen <= LENW'(MAXW));

    // Next-state and datapath update; a restart overrides whatever the state would do.
    always_comb begin
        stateNext   = state;
        wordNext    = outWord;
        countNext   = count;
        lenNext     = outLen;
        droppedNext = dropped;
        lenErrNext  = lenErr;
        restart     = 1'b0;

        case (state)
            IDLE: begin
                restart = start;
            end
            COLLECT: begin
                if (start) begin
                    restart = 1'b1;
                end else if (RXReady) begin
                    wordNext[count] = RXData;
                    countNext       = count + LENW'(1);
                    if (countNext == outLen) begin
                        stateNext = DONE;
                    end
                end
            end
            DONE: begin
                if (outAccept) begin
                    stateNext = IDLE;
                    restart   = start;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (restart) begin
            if (lenOk) begin
                stateNext   = COLLECT;
                lenNext     = wordLen;
                countNext   = '0;
                wordNext    = '0;
                droppedNext = 1'b0;
                lenErrNext  = 1'b0;
            end else begin
                stateNext  = IDLE;
                lenErrNext = 1'b1;
            end
        end

        // A bit offered while not collecting is lost.
        if (RXReady && (state != COLLECT)) begin
            droppedNext = 1'b1;
        end
    end

    always_ff @(posedge RXClk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            count    <= '0;
            outWord  <= '0;
            outLen   <= '0;
            outValid <= 1'b0;
            RXAccept <= 1'b0;
            busy     <= 1'b0;
            dropped  <= 1'b0;
            lenErr   <= 1'b0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            outWord  <= wordNext;
            outLen   <= lenNext;
            outValid <= (stateNext == DONE);
            RXAccept <= (stateNext == COLLECT);
            busy     <= (stateNext != IDLE);
            dropped  <= droppedNext;
            lenErr   <= lenErrNext;
        end
    end

endmodule
